// File: rtl/snoop_bus_ctrl_if.sv
// Snoop bus bundle between the bus controller (master) and the caches/memory (slave).
interface snoop_bus_ctrl_if #(
    parameter int unsigned NCACHE = 4
);
    logic [NCACHE-1:0]   req;
    logic [2*NCACHE-1:0] req_type;
    logic [NCACHE-1:0]   gnt;
    logic                BusRd_out;
    logic                BusRdX_out;
    logic                BusUpgr_out;
    logic [NCACHE-1:0]   snoop_vld;
    logic [NCACHE-1:0]   shared_in;
    logic [NCACHE-1:0]   flush_in;
    logic                C_out;
    logic                mem_rd_req;
    logic                mem_wr_req;
    logic                mem_ack;
    logic [NCACHE-1:0]   done;
    logic                err;

    // Controller side
    modport master (
        input  req, req_type, shared_in, flush_in, mem_ack,
        output gnt, BusRd_out, BusRdX_out, BusUpgr_out, snoop_vld,
               C_out, mem_rd_req, mem_wr_req, done, err
    );

    // Cache / memory side
    modport slave (
        output req, req_type, shared_in, flush_in, mem_ack,
        input  gnt, BusRd_out, BusRdX_out, BusUpgr_out, snoop_vld,
               C_out, mem_rd_req, mem_wr_req, done, err
    );
endinterface

// File: rtl/snoop_bus_ctrl.sv
// MESI snoop bus controller: round-robin arbitration, snoop broadcast,
// flush write-back / memory read phase and completion pulse.
module snoop_bus_ctrl #(
    parameter int unsigned NCACHE = 4
) (
    input  logic              clk,
    input  logic              rst,
    snoop_bus_ctrl_if.master  bus
);
    localparam int unsigned RW = (NCACHE > 1) ? $clog2(NCACHE) : 1;

    localparam logic [1:0] T_RD   = 2'b01;
    localparam logic [1:0] T_RDX  = 2'b10;
    localparam logic [1:0] T_UPGR = 2'b11;

    typedef enum logic [2:0] {IDLE, SNOOP, FLUSH_WB, MEM_RD, DONE} state_t;

    state_t          state;
    logic [RW-1:0]   rr;
    logic [RW-1:0]   own;
    logic [1:0]      typ;
    logic            c_cap;

    logic            found_c;
    logic [RW-1:0]   pick_c;
    logic [1:0]      pick_type_c;
    logic [RW-1:0]   idx_c;
    logic [NCACHE-1:0] mflush_c;
    logic            multi_c;

    // Round-robin search for the first eligible requester after rr
    always_comb begin
        found_c     = 1'b0;
        pick_c      = '0;
        pick_type_c = 2'b00;
        idx_c       = '0;
        for (int unsigned k = 1; k <= NCACHE; k++) begin
            idx_c = RW'((32'(rr) + k) % NCACHE);
            if (!found_c && bus.req[idx_c] && (bus.req_type[{idx_c, 1'b0} +: 2] != 2'b00)) begin
                found_c     = 1'b1;
                pick_c      = idx_c;
                pick_type_c = bus.req_type[{idx_c, 1'b0} +: 2];
            end
        end
    end

    // Flush responses from snoopers only (owner's own bits masked out)
    always_comb begin
        mflush_c = bus.flush_in & bus.snoop_vld;
        multi_c  = ($countones(mflush_c) > 1);
    end

    // Transaction FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            rr              <= RW'(NCACHE - 1);
            own             <= '0;
            typ             <= 2'b00;
            c_cap           <= 1'b0;
            bus.gnt         <= '0;
            bus.BusRd_out   <= 1'b0;
            bus.BusRdX_out  <= 1'b0;
            bus.BusUpgr_out <= 1'b0;
            bus.snoop_vld   <= '0;
            bus.C_out       <= 1'b0;
            bus.mem_rd_req  <= 1'b0;
            bus.mem_wr_req  <= 1'b0;
            bus.done        <= '0;
            bus.err         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found_c) begin
                        own             <= pick_c;
                        typ             <= pick_type_c;
                        bus.gnt         <= NCACHE'(1) << pick_c;
                        bus.snoop_vld   <= ~(NCACHE'(1) << pick_c);
                        bus.BusRd_out   <= (pick_type_c == T_RD);
                        bus.BusRdX_out  <= (pick_type_c == T_RDX);
                        bus.BusUpgr_out <= (pick_type_c == T_UPGR);
                        state           <= SNOOP;
                    end
                end
                SNOOP: begin
                    bus.BusRd_out   <= 1'b0;
                    bus.BusRdX_out  <= 1'b0;
                    bus.BusUpgr_out <= 1'b0;
                    bus.snoop_vld   <= '0;
                    c_cap <= (|((bus.shared_in | bus.flush_in) & bus.snoop_vld)) && (typ == T_RD);
                    if (typ == T_UPGR) begin
                        bus.done  <= bus.gnt;
                        bus.C_out <= 1'b0;
                        state     <= DONE;
                    end else if (|mflush_c) begin
                        if (multi_c) begin
                            bus.err <= 1'b1;
                        end
                        bus.mem_wr_req <= 1'b1;
                        state          <= FLUSH_WB;
                    end else begin
                        bus.mem_rd_req <= 1'b1;
                        state          <= MEM_RD;
                    end
                end
                FLUSH_WB: begin
                    if (bus.mem_ack) begin
                        bus.mem_wr_req <= 1'b0;
                        bus.done       <= bus.gnt;
                        bus.C_out      <= c_cap;
                        state          <= DONE;
                    end
                end
                MEM_RD: begin
                    if (bus.mem_ack) begin
                        bus.mem_rd_req <= 1'b0;
                        bus.done       <= bus.gnt;
                        bus.C_out      <= c_cap;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    bus.done  <= '0;
                    bus.C_out <= 1'b0;
                    bus.gnt   <= '0;
                    rr        <= own;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Directed bench for snoop_bus_ctrl: transaction table plus reset/arbitration sequences.
module tb_snoop_bus_ctrl;
    localparam int unsigned NC = 4;

    logic clk = 1'b0;
    logic rst;

    snoop_bus_ctrl_if #(.NCACHE(NC)) bus ();

    snoop_bus_ctrl #(.NCACHE(NC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] req;
        logic [7:0] rtype;
        logic [3:0] shared;
        logic [3:0] flush;
        int         delay;
        logic [3:0] e_gnt;
        logic [2:0] e_cmd;   // {BusRd, BusRdX, BusUpgr}
        logic [3:0] e_snoop;
        int         e_lat;
        int         e_wr;
        int         e_rd;
        logic       e_c;
        logic       e_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({bus.gnt, bus.snoop_vld, bus.done, bus.BusRd_out, bus.BusRdX_out,
                    bus.BusUpgr_out, bus.C_out, bus.mem_rd_req, bus.mem_wr_req, bus.err});
    endfunction

    // One full transaction: grant, snoop phase, memory phase, done pulse, IDLE return
    task automatic run_txn(input vec_t v, input int id);
        int  cyc;
        int  wr;
        int  rd;
        int  mcnt;
        bit  seen;
        bit  c_bad;
        bus.req       = v.req;
        bus.req_type  = v.rtype;
        bus.shared_in = v.shared;
        bus.flush_in  = v.flush;
        bus.mem_ack   = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("v%0d_gnt", id), 32'(bus.gnt), 32'(v.e_gnt));
        chk($sformatf("v%0d_cmd", id), 32'({bus.BusRd_out, bus.BusRdX_out, bus.BusUpgr_out}), 32'(v.e_cmd));
        chk($sformatf("v%0d_snoop_vld", id), 32'(bus.snoop_vld), 32'(v.e_snoop));
        // latched request must survive req/type being withdrawn; ack in SNOOP is ignored
        bus.req      = '0;
        bus.req_type = '0;
        bus.mem_ack  = 1'b1;
        c_bad = (bus.C_out !== 1'b0) || (bus.done !== 4'b0);
        cyc = 1; wr = 0; rd = 0; mcnt = 0; seen = 1'b0;
        while (!seen && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.mem_wr_req) wr++;
            if (bus.mem_rd_req) rd++;
            if (bus.mem_wr_req || bus.mem_rd_req) begin
                mcnt++;
                bus.mem_ack = (mcnt > v.delay);
            end else begin
                bus.mem_ack = 1'b0;
            end
            if (bus.done != 4'b0) begin
                seen = 1'b1;
                chk($sformatf("v%0d_done", id), 32'(bus.done), 32'(v.e_gnt));
                chk($sformatf("v%0d_c_out", id), 32'(bus.C_out), 32'(v.e_c));
                chk($sformatf("v%0d_lat", id), 32'(cyc), 32'(v.e_lat));
            end else if (bus.C_out !== 1'b0) begin
                c_bad = 1'b1;
            end
        end
        if (!seen) begin
            chk($sformatf("v%0d_done_timeout", id), 32'(0), 32'(1));
        end
        chk($sformatf("v%0d_wr_cycles", id), 32'(wr), 32'(v.e_wr));
        chk($sformatf("v%0d_rd_cycles", id), 32'(rd), 32'(v.e_rd));
        chk($sformatf("v%0d_c_outside_done", id), 32'(c_bad), 32'(0));
        @(posedge clk); #1;
        chk($sformatf("v%0d_idle", id), 32'({bus.gnt, bus.done}), 32'(0));
        chk($sformatf("v%0d_err", id), 32'(bus.err), 32'(v.e_err));
    endtask

    initial begin
        int   gcnt;
        int   last_cyc;
        bit   done_seen;
        logic [3:0] prev_gnt;
        logic [3:0] exp_order [5];
        vec_t v;

        //        req     rtype        shared   flush    dly gnt     cmd     snoop   lat wr rd C     err
        vecs[0] = '{4'b0001, 8'b00_00_00_01, 4'b0000, 4'b0000, 0, 4'b0001, 3'b100, 4'b1110, 3, 0, 1, 1'b0, 1'b0};
        vecs[1] = '{4'b0100, 8'b00_01_00_00, 4'b0000, 4'b0001, 3, 4'b0100, 3'b100, 4'b1011, 6, 4, 0, 1'b1, 1'b0};
        vecs[2] = '{4'b0010, 8'b00_00_11_00, 4'b1101, 4'b0000, 0, 4'b0010, 3'b001, 4'b1101, 2, 0, 0, 1'b0, 1'b0};
        vecs[3] = '{4'b1000, 8'b01_00_00_00, 4'b0010, 4'b0000, 1, 4'b1000, 3'b100, 4'b0111, 4, 0, 2, 1'b1, 1'b0};
        vecs[4] = '{4'b0010, 8'b00_00_10_00, 4'b0001, 4'b0000, 0, 4'b0010, 3'b010, 4'b1101, 3, 0, 1, 1'b0, 1'b0};
        vecs[5] = '{4'b0001, 8'b00_00_00_01, 4'b0001, 4'b0001, 0, 4'b0001, 3'b100, 4'b1110, 3, 0, 1, 1'b0, 1'b0};
        vecs[6] = '{4'b0011, 8'b00_00_01_00, 4'b0000, 4'b0000, 0, 4'b0010, 3'b100, 4'b1101, 3, 0, 1, 1'b0, 1'b0};
        vecs[7] = '{4'b0001, 8'b00_00_00_10, 4'b0000, 4'b0110, 0, 4'b0001, 3'b010, 4'b1110, 3, 1, 0, 1'b0, 1'b1};

        rst = 1'b1;
        bus.req = '0; bus.req_type = '0; bus.shared_in = '0; bus.flush_in = '0; bus.mem_ack = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_outputs", all_outs(), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], i);
        end

        // Sticky error survives a clean upgrade by cache 1 (rr becomes 1)
        v = '{4'b0010, 8'b00_00_11_00, 4'b0000, 4'b0000, 0, 4'b0010, 3'b001, 4'b1101, 2, 0, 0, 1'b0, 1'b1};
        run_txn(v, 8);

        // Abort a cache-2 read in MEM_RD with an asynchronous reset
        bus.req = 4'b0100; bus.req_type = 8'b00_01_00_00; bus.flush_in = '0; bus.shared_in = '0;
        bus.mem_ack = 1'b0;
        @(posedge clk); #1;
        bus.req = '0; bus.req_type = '0;
        @(posedge clk); #1;
        chk("abort_in_mem_rd", 32'(bus.mem_rd_req), 32'(1));
        #2 rst = 1'b1;
        #1;
        chk("abort_outputs_async", all_outs(), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.done != 4'b0 || bus.mem_rd_req) done_seen = 1'b1;
        end
        chk("abort_no_done", 32'(done_seen), 32'(0));

        // Rotation with all four requesting: 0,1,2,3,0 with a 4-cycle period (1-cycle IDLE gap)
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
        bus.req = 4'b1111; bus.req_type = 8'b01_01_01_01; bus.mem_ack = 1'b1;
        gcnt = 0; last_cyc = 0; prev_gnt = '0;
        for (int c = 1; c <= 40 && gcnt < 5; c++) begin
            @(posedge clk); #1;
            if (bus.gnt != 4'b0 && prev_gnt == 4'b0) begin
                chk($sformatf("arb_gnt%0d", gcnt), 32'(bus.gnt), 32'(exp_order[gcnt]));
                if (gcnt > 0) chk($sformatf("arb_period%0d", gcnt), 32'(c - last_cyc), 32'(4));
                last_cyc = c;
                gcnt++;
            end
            prev_gnt = bus.gnt;
        end
        chk("arb_grant_count", 32'(gcnt), 32'(5));
        bus.req = '0; bus.req_type = '0; bus.mem_ack = 1'b0;
        repeat (6) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/snoop_bus_ctrl.md
SNOOP_BUS_CTRL -- requirements
Module: snoop_bus_ctrl

Interface
REQ-001 The block SHALL have parameter NCACHE, default 4, giving the number of attached MESI cache controllers.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req, input, NCACHE bits: cache i requests the bus.
REQ-005 The block SHALL have port req_type, input, 2*NCACHE bits: bits [2i+1:2i] give cache i's command; 01 = BusRd, 10 = BusRdX, 11 = BusUpgr, 00 = none.
REQ-006 The block SHALL have port gnt, output, NCACHE bits: one-hot owner of the current transaction.
REQ-007 The block SHALL have ports BusRd_out, BusRdX_out and BusUpgr_out, output, 1 bit each: the broadcast snoop command.
REQ-008 The block SHALL have port snoop_vld, output, NCACHE bits: snoop strobe to every cache except the owner.
REQ-009 The block SHALL have port shared_in, input, NCACHE bits: snooper i holds the line.
REQ-010 The block SHALL have port flush_in, input, NCACHE bits: snooper i flushes a dirty line.
REQ-011 The block SHALL have port C_out, output, 1 bit: shared indication to the owner.
REQ-012 The block SHALL have ports mem_rd_req and mem_wr_req, output, 1 bit each, and port mem_ack, input, 1 bit: the memory handshake.
REQ-013 The block SHALL have port done, output, NCACHE bits: one-cycle completion pulse to the owner.
REQ-014 The block SHALL have port err, output, 1 bit: sticky protocol-error flag.

Function
REQ-015 The block SHALL implement a Moore FSM with states IDLE, SNOOP, FLUSH_WB, MEM_RD and DONE, plus a round-robin pointer rr of width clog2(NCACHE).
REQ-016 In IDLE, a cache is eligible only when req[i]=1 and its req_type is not 00.
REQ-017 In IDLE, when any cache is eligible, the block SHALL latch the first eligible index searching upward from rr+1 (mod NCACHE), latch its type, and enter SNOOP on the next edge.
REQ-018 gnt SHALL be one-hot for the latched owner in states SNOOP through DONE, and zero in IDLE.
REQ-019 Deassertion of req or a change of req_type after latching SHALL be ignored until DONE.
REQ-020 In SNOOP, which lasts exactly 1 cycle, the block SHALL assert exactly one of BusRd_out, BusRdX_out or BusUpgr_out, matching the latched type.
REQ-021 In SNOOP, snoop_vld SHALL equal the inverse of the owner's one-hot.
REQ-022 In SNOOP, the block SHALL sample shared_in and flush_in masked by snoop_vld.
REQ-023 SNOOP exit, BusUpgr: go to DONE, with no memory access and no data phase.
REQ-024 SNOOP exit, BusRd or BusRdX with exactly one masked flush bit set: go to FLUSH_WB.
REQ-025 SNOOP exit, BusRd or BusRdX with more than one masked flush bit set: set err, then go to FLUSH_WB.
REQ-026 SNOOP exit, BusRd or BusRdX with no masked flush bit set: go to MEM_RD.
REQ-027 In FLUSH_WB, mem_wr_req SHALL be held at 1 until mem_ack is sampled high, then the FSM SHALL go to DONE; data reaches the owner cache-to-cache.
REQ-028 In MEM_RD, mem_rd_req SHALL be held at 1 until mem_ack is sampled high, then the FSM SHALL go to DONE.
REQ-029 mem_ack SHALL be ignored in IDLE, SNOOP and DONE.
REQ-030 C_out SHALL be valid in DONE only; C_out = OR of the masked shared_in and flush_in captured in SNOOP, forced to 0 for BusRdX and BusUpgr.
REQ-031 In DONE, which lasts 1 cycle, done[owner] SHALL pulse, rr SHALL be loaded with the owner index, and the FSM SHALL return to IDLE.
REQ-032 A new request SHALL be accepted no earlier than the cycle after DONE, giving a minimum 1-cycle IDLE gap.
REQ-033 Latency from the req-sampling edge to done: BusUpgr 2 cycles; read with mem_ack on first cycle 3 cycles; plus 1 cycle per extra mem_ack wait cycle.
REQ-034 Simultaneous eligible requests SHALL be served one per transaction in rotating order; no cache waits more than NCACHE-1 transactions.
REQ-035 Once set, err SHALL remain set until reset.

Reset
REQ-036 On rst=1, immediately and asynchronously: state=IDLE, rr=NCACHE-1 (so cache 0 has first priority), and all outputs (gnt, bus commands, snoop_vld, C_out, mem_rd_req, mem_wr_req, done, err) = 0.
REQ-037 Reset asserted mid-transaction SHALL abort the transaction, with no done pulse and memory requests dropped; the first request after reset release SHALL be arbitrated from cache 0.

Verification
REQ-038 Read, unshared: req=0001, type BusRd, shared_in=0, mem_ack on the first MEM_RD cycle -> gnt=0001; BusRd_out pulse with snoop_vld=1110; done=0001 3 cycles after sampling; C_out=0.
REQ-039 Read hits a dirty copy: cache 2 BusRd, flush_in=0001 in SNOOP, mem_ack delayed 3 cycles -> FLUSH_WB with mem_wr_req high for 4 cycles, no mem_rd_req, C_out=1, done=0100.
REQ-040 Upgrade: cache 1 BusUpgr with shared_in=1101 -> BusUpgr_out for 1 cycle, no memory request, done=0010 after 2 cycles, C_out=0.
REQ-041 Arbitration: req=1111 held, all BusRd -> grant order 0,1,2,3,0, with a 1-cycle IDLE gap between transactions.
REQ-042 Errors and abort: flush_in=0110 for a cache-0 BusRdX -> err=1 sticky and the transaction completes; rst pulsed during MEM_RD -> all outputs 0 at once, no done.
